demux_dispatch_ctrl: RTL and testbench
======================================

# demux_dispatch_ctrl

Sequencing controller for the 1-to-N demux datapath: accepts a word stream on a valid/ready input and dispatches each word to exactly one of N destination channels. It chooses the destination by round-robin over fixed-length bursts or by a fixed software-selected channel. One registered output stage holds the word and its select until the addressed destination accepts it. The block sits between a single producer and N consumers and drives a shared data bus plus a one-hot valid vector.

## Interface
- N, 4: number of destination channels, N ≥ 2, need not be a power of two.
- W, 8: data width.
- BURST, 2: words sent to one channel before the round-robin target advances, BURST ≥ 1.
- SW (localparam) = $clog2(N).

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_mode  in  1  0 = round-robin, 1 = fixed channel.
- cfg_sel  in  SW  fixed-mode target channel.
- in_valid  in  1  producer has a word.
- in_data  in  W  producer word.
- in_ready  out  1  controller can accept a word (combinational).
- out_valid  out  N  one-hot, registered; bit k means out_data is for channel k.
- out_data  out  W  registered shared data bus.
- out_sel  out  SW  registered binary index of the held word's channel.
- out_ready  in  N  per-channel accept.
- busy  out  1  registered; high while a burst is in progress (bcnt ≠ 0) or a word is held.

## Operation
- Internal state:
  - full: output stage holds a word.
  - rr_ptr: next round-robin channel.
  - burst_tgt: channel of the current burst.
  - bcnt: words accepted in the current burst, 0..BURST-1.
- Output fire: full && out_ready[out_sel]. Other out_ready bits are ignored.
- Input accept: in_valid && in_ready, where in_ready = !full || fire. Simultaneous fire and accept is allowed (full pass-through, no bubble).
- Target for an accepted word:
  - If bcnt == 0 (burst start): tgt = cfg_mode ? cfg_sel_c : rr_ptr. cfg_sel_c = cfg_sel if cfg_sel < N, else 0. tgt is latched into burst_tgt.
  - Otherwise: tgt = burst_tgt.
- cfg_mode and cfg_sel are sampled only at burst start. Changes mid-burst take effect at the next burst.
- On accept:
  - out_data ← in_data, out_sel ← tgt, out_valid ← onehot(tgt), full ← 1.
  - bcnt ← (bcnt == BURST-1) ? 0 : bcnt+1.
- At burst end (accept with bcnt == BURST-1) in round-robin mode: rr_ptr ← (tgt == N-1) ? 0 : tgt+1. In fixed mode rr_ptr is unchanged.
- On fire without accept: full ← 0, out_valid ← 0. out_data and out_sel hold their last values.
- BURST = 1: every accepted word is a burst start; the round-robin target advances every word.
- State machine (full): EMPTY → HOLD on accept; HOLD → EMPTY on fire without accept; HOLD → HOLD on fire with accept, or on no fire.
- Values of out_ready on non-addressed channels never stall or advance the block.

## Timing
- Reset (rst high at an edge): out_valid = 0, out_data = 0, out_sel = 0, full = 0, busy = 0, rr_ptr = 0, burst_tgt = 0, bcnt = 0. in_ready is 1 in the cycle after reset.
- Reset mid-operation discards any held word and any partial burst.
- in_ready and every output are 0 during any cycle with rst high.
- Latency: a word accepted at edge k is presented on out_valid/out_data from edge k (visible in cycle k+1).
- Throughput: 1 word per cycle while the addressed channel holds out_ready high.
- Stall: while full and out_ready[out_sel] is low, in_ready = 0 and out_data, out_sel, out_valid are stable.
- Held words never change channel, even if cfg_* changes.
- busy falls in the cycle after the last held word of a completed burst fires.

## Test plan
- Round-robin: N=4, BURST=2, all out_ready=1, cfg_mode=0, stream 8 words 0x10..0x17 → channels 0,0,1,1,2,2,3,3. Next word wraps to channel 0. One word per cycle, each appearing one cycle after accept.
- Fixed mode: cfg_mode=1, cfg_sel=2, 4 words → all words on out_valid=4'b0100. cfg_sel=5 with N=6 → channel 5. cfg_sel=7 with N=6 → channel 0.
- Stall/backpressure: hold out_ready[1]=0 while word 0xA5 is held for channel 1, with out_ready[0]=1 → in_ready=0, out_data=0xA5 stable. Release → fire that cycle, and a new word is accepted in the same cycle.
- Mid-burst config change: round-robin, BURST=2, first word to channel 0, then switch cfg_mode=1, cfg_sel=3 → second word still goes to channel 0, third word goes to channel 3.
- Reset mid-operation: rst=1 for 1 cycle while a word is held and bcnt=1 → all outputs 0, next accepted word goes to channel 0 with bcnt restarting.
- BURST=1, N=3: 4 words → channels 0,1,2,0.

Source files
------------

// File: rtl/demux_dispatch_ctrl.sv
// One-to-N dispatch controller: routes each accepted word to one channel chosen
// by burst-wise round-robin or a fixed channel, through a single registered output stage.
module demux_dispatch_ctrl #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int BURST = 2,
  localparam int SW   = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_mode,
  input  logic [SW-1:0] cfg_sel,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          in_ready,
  output logic [N-1:0]  out_valid,
  output logic [W-1:0]  out_data,
  output logic [SW-1:0] out_sel,
  input  logic [N-1:0]  out_ready,
  output logic          busy
);

  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [SW:0]   NUM_CH    = (SW+1)'(N);
  localparam logic [SW-1:0] LAST_CH   = SW'(N-1);
  localparam logic [BW-1:0] LAST_BCNT = BW'(BURST-1);

  typedef enum logic {EMPTY, HOLD} state_t;

  state_t          state_reg, state_next;
  logic [W-1:0]    data_reg;
  logic [SW-1:0]   sel_reg;
  logic [N-1:0]    valid_reg;
  logic [SW-1:0]   rr_ptr_reg;
  logic [SW-1:0]   burst_tgt_reg;
  logic            burst_mode_reg;
  logic [BW-1:0]   bcnt_reg, bcnt_next;
  logic            busy_reg;

  logic            full, fire, accept, load_word, drop_word;
  logic            burst_start, burst_end, mode_eff;
  logic [SW-1:0]   sel_c, tgt, rr_next;
  logic [N-1:0]    tgt_onehot;

  assign fire        = full && out_ready[sel_reg];
  assign in_ready    = !rst && (!full || fire);
  assign accept      = in_valid && in_ready;
  assign burst_start = (bcnt_reg == '0);
  assign burst_end   = (bcnt_reg == LAST_BCNT);

  // Out-of-range fixed selections fall back to channel 0.
  assign sel_c    = ({1'b0, cfg_sel} < NUM_CH) ? cfg_sel : '0;
  assign tgt      = burst_start ? (cfg_mode ? sel_c : rr_ptr_reg) : burst_tgt_reg;
  assign mode_eff = burst_start ? cfg_mode : burst_mode_reg;
  assign rr_next  = (tgt == LAST_CH) ? '0 : tgt + SW'(1);

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
      assign tgt_onehot[gi] = (tgt == SW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state_reg <= EMPTY;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY:   if (accept) state_next = HOLD;
      HOLD:    if (fire && !accept) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    full      = (state_reg == HOLD);
    load_word = accept;
    drop_word = fire && !accept;
  end

  always_comb begin
    bcnt_next = bcnt_reg;
    if (accept) bcnt_next = burst_end ? '0 : bcnt_reg + BW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg       <= '0;
      sel_reg        <= '0;
      valid_reg      <= '0;
      rr_ptr_reg     <= '0;
      burst_tgt_reg  <= '0;
      burst_mode_reg <= 1'b0;
      bcnt_reg       <= '0;
      busy_reg       <= 1'b0;
    end else begin
      bcnt_reg <= bcnt_next;
      busy_reg <= (state_next == HOLD) || (bcnt_next != '0);
      if (load_word) begin
        data_reg  <= in_data;
        sel_reg   <= tgt;
        valid_reg <= tgt_onehot;
        if (burst_start) begin
          burst_tgt_reg  <= tgt;
          burst_mode_reg <= cfg_mode;
        end
        // The round-robin pointer only moves once a burst launched in that mode completes.
        if (burst_end && !mode_eff) rr_ptr_reg <= rr_next;
      end else if (drop_word) begin
        valid_reg <= '0;
      end
    end
  end

  assign out_valid = rst ? '0 : valid_reg;
  assign out_data  = rst ? '0 : data_reg;
  assign out_sel   = rst ? '0 : sel_reg;
  assign busy      = rst ? 1'b0 : busy_reg;

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Scoreboard bench: three controller instances (N/BURST = 4/2, 6/1, 3/1) share one
// stimulus stream; a burst-level reference model predicts each word's channel.
module tb_demux_dispatch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_mode = 1'b0;
  logic [2:0] cfg_sel = '0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic [5:0] rdy = '1;

  always #5 clk = ~clk;

  logic [3:0] ov_a; logic [7:0] od_a; logic [1:0] os_a; logic bz_a, ir_a;
  logic [5:0] ov_b; logic [7:0] od_b; logic [2:0] os_b; logic bz_b, ir_b;
  logic [2:0] ov_c; logic [7:0] od_c; logic [1:0] os_c; logic bz_c, ir_c;

  demux_dispatch_ctrl #(.N(4), .W(8), .BURST(2)) dut_a (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_sel(cfg_sel[1:0]),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ir_a),
    .out_valid(ov_a), .out_data(od_a), .out_sel(os_a), .out_ready(rdy[3:0]), .busy(bz_a));

  demux_dispatch_ctrl #(.N(6), .W(8), .BURST(1)) dut_b (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_sel(cfg_sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ir_b),
    .out_valid(ov_b), .out_data(od_b), .out_sel(os_b), .out_ready(rdy), .busy(bz_b));

  demux_dispatch_ctrl #(.N(3), .W(8), .BURST(1)) dut_c (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_sel(cfg_sel[1:0]),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ir_c),
    .out_valid(ov_c), .out_data(od_c), .out_sel(os_c), .out_ready(rdy[2:0]), .busy(bz_c));

  logic [5:0] ov[3];
  logic [7:0] od[3];
  logic [2:0] os[3];
  logic       bz[3];
  logic       ir[3];

  assign ov[0] = {2'b00, ov_a}; assign od[0] = od_a; assign os[0] = {1'b0, os_a};
  assign ov[1] = ov_b;          assign od[1] = od_b; assign os[1] = os_b;
  assign ov[2] = {3'b000, ov_c}; assign od[2] = od_c; assign os[2] = {1'b0, os_c};
  assign bz[0] = bz_a; assign bz[1] = bz_b; assign bz[2] = bz_c;
  assign ir[0] = ir_a; assign ir[1] = ir_b; assign ir[2] = ir_c;

  localparam int NS[3]  = '{4, 6, 3};
  localparam int BS[3]  = '{2, 1, 1};
  localparam int SWS[3] = '{2, 3, 2};

  int errors = 0;
  int checks = 0;

  // Model state per instance; expected items are channel*256 + data.
  int exq[3][$];
  int m_cnt[3];
  int m_rr[3];
  int m_btgt[3];
  int m_bmode[3];

  task automatic chk(input string nm, input int k, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h", nm, k, got, exp);
    end
  endtask

  task automatic model_reset(input int k);
    exq[k].delete();
    m_cnt[k] = 0; m_rr[k] = 0; m_btgt[k] = 0; m_bmode[k] = 0;
  endtask

  task automatic model_accept(input int k, input int d, input int m, input int s);
    int sm, ch;
    sm = s % (1 << SWS[k]);
    if (m_cnt[k] == 0) begin
      ch = (m != 0) ? ((sm < NS[k]) ? sm : 0) : m_rr[k];
      m_btgt[k] = ch;
      m_bmode[k] = m;
    end else begin
      ch = m_btgt[k];
    end
    m_cnt[k]++;
    if (m_cnt[k] == BS[k]) begin
      m_cnt[k] = 0;
      if (m_bmode[k] == 0) m_rr[k] = (ch + 1) % NS[k];
    end
    exq[k].push_back(ch * 256 + d);
  endtask

  // Monitor: compares the presented word against the scoreboard head and retires it on fire.
  always @(negedge clk) begin
    int it, ch;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        chk("rst_valid", k, int'(ov[k]), 0);
        chk("rst_data", k, int'(od[k]), 0);
        chk("rst_sel", k, int'(os[k]), 0);
        chk("rst_busy", k, int'(bz[k]), 0);
      end else if (exq[k].size() > 0) begin
        it = exq[k][0];
        ch = it / 256;
        chk("valid", k, int'(ov[k]), 1 << ch);
        chk("data", k, int'(od[k]), it % 256);
        chk("sel", k, int'(os[k]), ch);
        chk("busy_full", k, int'(bz[k]), 1);
        if (rdy[ch]) begin
          $display("dut%0d fire ch%0d data %02h", k, ch, it % 256);
          void'(exq[k].pop_front());
        end
      end else begin
        chk("idle_valid", k, int'(ov[k]), 0);
        chk("busy_idle", k, int'(bz[k]), (m_cnt[k] != 0) ? 1 : 0);
      end
    end
  end

  task automatic step(input logic v, input logic [7:0] d, input logic m,
                      input logic [2:0] s, input logic [5:0] r, input logic rs);
    int exp_rdy;
    @(posedge clk);
    #1;
    in_valid = v; in_data = d; cfg_mode = m; cfg_sel = s; rdy = r; rst = rs;
    @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (rs) begin
        chk("rst_in_ready", k, int'(ir[k]), 0);
        model_reset(k);
      end else begin
        exp_rdy = (exq[k].size() == 0) ? 1 : 0;
        chk("in_ready", k, int'(ir[k]), exp_rdy);
        if (v && exp_rdy != 0) model_accept(k, int'(d), int'(m), int'(s));
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) model_reset(k);
    step(0, 8'h00, 0, 0, 6'h3f, 1);
    step(0, 8'h00, 0, 0, 6'h3f, 1);
    step(0, 8'h00, 0, 0, 6'h3f, 0);
    // Round-robin stream, including wrap back to channel 0.
    for (int i = 0; i < 10; i++) step(1, 8'(8'h10 + i), 0, 0, 6'h3f, 0);
    // Fixed channel, then out-of-range selections.
    for (int i = 0; i < 4; i++) step(1, 8'(8'h20 + i), 1, 3'd2, 6'h3f, 0);
    step(1, 8'h28, 1, 3'd5, 6'h3f, 0);
    step(1, 8'h29, 1, 3'd5, 6'h3f, 0);
    step(1, 8'h2a, 1, 3'd7, 6'h3f, 0);
    step(1, 8'h2b, 1, 3'd7, 6'h3f, 0);
    // Backpressure on channel 1 while 0xA5 is held, then release.
    step(1, 8'ha5, 0, 0, 6'h3d, 0);
    for (int i = 0; i < 4; i++) step(1, 8'ha6, 0, 0, 6'h3d, 0);
    step(1, 8'ha6, 0, 0, 6'h3f, 0);
    step(0, 8'h00, 0, 0, 6'h3f, 0);
    // Configuration change in the middle of a burst.
    step(0, 8'h00, 0, 0, 6'h3f, 1);
    step(1, 8'h30, 0, 0, 6'h3f, 0);
    step(1, 8'h31, 1, 3'd3, 6'h3f, 0);
    step(1, 8'h32, 1, 3'd3, 6'h3f, 0);
    step(0, 8'h00, 0, 0, 6'h3f, 0);
    // Reset while a word is held partway through a burst.
    step(0, 8'h00, 0, 0, 6'h3f, 1);
    step(1, 8'h40, 0, 0, 6'h00, 0);
    step(0, 8'h00, 0, 0, 6'h00, 1);
    step(1, 8'h41, 0, 0, 6'h3f, 0);
    step(1, 8'h42, 0, 0, 6'h3f, 0);
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) == 0),
           3'($urandom), 6'($urandom), ($urandom_range(0, 49) == 0));
    end
    for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 0, 6'h3f, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
